// File: rtl/rr_mux16_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 16-source round-robin mux arbiter.
package rr_mux16_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Pointer after reset: scanning starts at source 0.
    localparam logic [SEL_W-1:0] LAST_RST = 4'd15;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        return N_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_mux16_arbiter_pick.sv
// Rotating priority encoder (rr_pick16) and the 16:1 data mux used by the arbiter.
module rr_pick16
    import rr_mux16_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // rot[i] is the source i+1 positions after last; the source at last lands in rot[15].
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = vec[last + SEL_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        idx = last;
        any = |vec;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = last + SEL_W'(i + 1);
            end
        end
    end

endmodule

module rr_mux16
    import rr_mux16_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    input  logic [SEL_W-1:0] s,
    output logic             q
);

    assign q = d[s];

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter that time-slices one 16:1 serial mux among 16 requesters
// and gates the selected bit onto a shared output line.
module rr_mux16_arbiter
    import rr_mux16_arbiter_pkg::*;
#(
    parameter int SLOT_LEN = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             y,
    output logic             slot_end
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg,   sel_next;
    logic [N_REQ-1:0] gnt_reg,   gnt_next;
    logic             busy_reg,  busy_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [SEL_W-1:0] last_reg,  last_next;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             din_sel;
    logic             req_sel;
    logic             timeout;
    logic             slot_done;

    // A regrant scans from the source being released, so the pointer is the current sel.
    assign ptr = (state_reg == ST_GRANT) ? sel_reg : last_reg;

    rr_pick16 u_pick (
        .vec  (req),
        .last (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    rr_mux16 u_mux (
        .d (din),
        .s (sel_reg),
        .q (din_sel)
    );

    assign req_sel   = req[sel_reg];
    assign timeout   = (cnt_reg == CNT_W'(SLOT_LEN - 1));
    assign slot_done = (state_reg == ST_GRANT) && (!req_sel || timeout);

    // Reset abandons the slot silently: no end pulse and no data.
    assign slot_end = slot_done & ~rst;
    assign y        = busy_reg & req_sel & din_sel & ~rst;
    assign sel      = sel_reg;
    assign gnt      = gnt_reg;
    assign busy     = busy_reg;

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        gnt_next   = gnt_reg;
        busy_next  = busy_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_GRANT;
                    sel_next   = pick_idx;
                    gnt_next   = onehot(pick_idx);
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                if (slot_done) begin
                    last_next = sel_reg;
                    cnt_next  = '0;
                    if (pick_any) begin
                        sel_next = pick_idx;
                        gnt_next = onehot(pick_idx);
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                        busy_next  = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            last_reg  <= LAST_RST;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            gnt_reg   <= gnt_next;
            busy_reg  <= busy_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// Directed bench for rr_mux16_arbiter with SLOT_LEN=4; each task checks one scenario.
module tb_rr_mux16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] din;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        y;
    logic        slot_end;

    int vectors    = 0;
    int miscompares = 0;

    rr_mux16_arbiter #(.SLOT_LEN(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .sel      (sel),
        .gnt      (gnt),
        .busy     (busy),
        .y        (y),
        .slot_end (slot_end)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int n, input logic [15:0] r);
        rst = 1'b1;
        req = r;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [20:0] exp_st;
        rst = 1'b1;
        req = 16'hFFFF;
        din = 16'hFFFF;
        #1;
        vectors++;
        if (y !== 1'b0 || slot_end !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_comb: y=%b slot_end=%b, expected 0 0", y, slot_end);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_st = {1'b0, 4'd0, 16'h0000};
            vectors++;
            if ({busy, sel, gnt} !== exp_st || y !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: {busy,sel,gnt}=%h y=%b, expected %h y=0", k, {busy, sel, gnt}, y, exp_st);
            end
        end
        rst = 1'b0;
        tick();
        exp_st = {1'b1, 4'd0, 16'h0001};
        vectors++;
        if ({busy, sel, gnt} !== exp_st || y !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant: {busy,sel,gnt}=%h y=%b, expected %h y=1", {busy, sel, gnt}, y, exp_st);
        end
    endtask

    task automatic test_single_holder();
        logic exp_y;
        reset_dut(1, 16'h0000);
        req = 16'h0020;
        din = 16'h0000;
        tick();
        for (int k = 0; k < 12; k++) begin
            din   = ((k % 3) == 1) ? 16'hFFDF : 16'h0020;
            exp_y = ((k % 3) != 1);
            #1;
            vectors++;
            if ({busy, sel, gnt} !== {1'b1, 4'd5, 16'h0020} || slot_end !== ((k % 4) == 3) || y !== exp_y) begin
                miscompares++;
                $display("FAIL single_holder[%0d]: {busy,sel,gnt}=%h slot_end=%b y=%b, expected %h slot_end=%b y=%b",
                         k, {busy, sel, gnt}, slot_end, y, {1'b1, 4'd5, 16'h0020}, ((k % 4) == 3), exp_y);
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_sel;
        reset_dut(1, 16'h0000);
        req = 16'h8001;
        din = 16'h0000;
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_sel = (((k / 4) % 2) == 1) ? 4'd15 : 4'd0;
            vectors++;
            if ({busy, sel, gnt} !== {1'b1, exp_sel, 16'(16'h0001 << exp_sel)}) begin
                miscompares++;
                $display("FAIL fairness[%0d]: {busy,sel,gnt}=%h, expected sel=%0d", k, {busy, sel, gnt}, exp_sel);
            end
            tick();
        end
    endtask

    task automatic test_early_release();
        reset_dut(1, 16'h0000);
        req = 16'h0208;
        din = 16'hFFFF;
        tick();
        vectors++;
        if ({busy, sel, gnt} !== {1'b1, 4'd3, 16'h0008} || slot_end !== 1'b0) begin
            miscompares++;
            $display("FAIL early_grant: {busy,sel,gnt}=%h slot_end=%b, expected %h slot_end=0", {busy, sel, gnt}, slot_end, {1'b1, 4'd3, 16'h0008});
        end
        tick();
        req = 16'h0200;
        #1;
        vectors++;
        if (gnt !== 16'h0008 || slot_end !== 1'b1 || y !== 1'b0) begin
            miscompares++;
            $display("FAIL early_release: gnt=%h slot_end=%b y=%b, expected 0008 1 0", gnt, slot_end, y);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({busy, sel, gnt} !== {1'b1, 4'd9, 16'h0200} || slot_end !== (k == 3)) begin
                miscompares++;
                $display("FAIL early_next[%0d]: {busy,sel,gnt}=%h slot_end=%b, expected %h slot_end=%b", k, {busy, sel, gnt}, slot_end, {1'b1, 4'd9, 16'h0200}, (k == 3));
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        reset_dut(1, 16'h0000);
        req = 16'h4000;
        din = 16'h0000;
        tick();
        req = 16'h4001;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({busy, sel, gnt} !== {1'b1, 4'd14, 16'h4000} || slot_end !== (k == 3)) begin
                miscompares++;
                $display("FAIL wrap_hold[%0d]: {busy,sel,gnt}=%h slot_end=%b, expected %h slot_end=%b", k, {busy, sel, gnt}, slot_end, {1'b1, 4'd14, 16'h4000}, (k == 3));
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({busy, sel, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
                miscompares++;
                $display("FAIL wrap_to_0[%0d]: {busy,sel,gnt}=%h, expected %h", k, {busy, sel, gnt}, {1'b1, 4'd0, 16'h0001});
            end
            tick();
        end
        vectors++;
        if ({busy, sel, gnt} !== {1'b1, 4'd14, 16'h4000}) begin
            miscompares++;
            $display("FAIL wrap_back_14: {busy,sel,gnt}=%h, expected %h", {busy, sel, gnt}, {1'b1, 4'd14, 16'h4000});
        end
    endtask

    task automatic test_mid_reset();
        reset_dut(1, 16'h0000);
        req = 16'h0080;
        din = 16'hFFFF;
        tick();
        vectors++;
        if ({busy, sel, gnt} !== {1'b1, 4'd7, 16'h0080}) begin
            miscompares++;
            $display("FAIL mid_grant7: {busy,sel,gnt}=%h, expected %h", {busy, sel, gnt}, {1'b1, 4'd7, 16'h0080});
        end
        tick();
        tick();
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_data: y=%b, expected 1", y);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (slot_end !== 1'b0 || y !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_comb: slot_end=%b y=%b, expected 0 0", slot_end, y);
        end
        tick();
        vectors++;
        if ({busy, sel, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
            miscompares++;
            $display("FAIL mid_rst_state: {busy,sel,gnt}=%h, expected 0", {busy, sel, gnt});
        end
        rst = 1'b0;
        req = 16'h0081;
        tick();
        vectors++;
        if ({busy, sel, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
            miscompares++;
            $display("FAIL mid_regrant: {busy,sel,gnt}=%h, expected %h", {busy, sel, gnt}, {1'b1, 4'd0, 16'h0001});
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 16'h0000;
        din = 16'h0000;
        test_reset();
        test_single_holder();
        test_fairness();
        test_early_release();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
